// File: rtl/store_write_buffer_pkg.sv
// rtl/store_write_buffer_pkg.sv - shared widths, byte-lane helpers for the store write buffer
// Purpose: entry field widths, the full-word byte-enable constant and the lane
//          mapping/merge helpers used by the buffer and its comparator.
// Ports:   none (package).
package store_write_buffer_pkg;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    localparam logic [BE_W-1:0] BE_WORD = 4'b1111;

    // Byte-enable bit i selects the lane whose MSB is returned here; bit 0 is
    // the most significant byte (bits 31:24), matching the store encoder.
    function automatic int lane_msb(input int lane);
        return DATA_W - 1 - 8 * lane;
    endfunction

    // Overwrite only the enabled lanes of old_data with new_data.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_data,
        input logic [DATA_W-1:0] new_data,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] merged;
        merged = old_data;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                merged[lane_msb(i) -: 8] = new_data[lane_msb(i) -: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/store_buf_match.sv
// rtl/store_buf_match.sv - DEPTH-way word-address comparator over the buffer entries
// Purpose: compares a key address against every entry and reports which valid
//          entries hold that word.
// Ports:   valid [DEPTH]          entry valid bits
//          addrs [DEPTH][ADDR_W]  entry word addresses
//          key   [ADDR_W]         address to look up
//          hit   [DEPTH]          per-entry match (valid & address equal)
module store_buf_match
    import store_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]             valid,
    input  logic [DEPTH-1:0][ADDR_W-1:0] addrs,
    input  logic [ADDR_W-1:0]            key,
    output logic [DEPTH-1:0]             hit
);

    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit[i] = valid[i] && (addrs[i] == key);
        end
    end

endmodule

// File: rtl/store_write_buffer.sv
// rtl/store_write_buffer.sv - posted in-order store buffer with youngest-entry merge and RAW check
// Purpose: queues encoded stores and drains them to memory over req/ack, so
//          stores do not stall on slow memory. Optionally byte-merges a store
//          into the youngest (non-head) entry, and flags loads that hit a
//          pending store.
// Ports:   clk, rst                        clock, synchronous active-high reset
//          wr_en/wr_addr/wr_data/wr_be     store issue from the encoder
//          full, empty, count              occupancy status
//          ld_chk_en/ld_chk_addr           load lookup; ld_hazard = hit on a pending store
//          mem_req/mem_addr/mem_wdata/mem_be, mem_ack   head-entry drain handshake
module store_write_buffer
    import store_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter bit MERGE = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [BE_W-1:0]            wr_be,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    input  logic                       ld_chk_en,
    input  logic [ADDR_W-1:0]          ld_chk_addr,
    output logic                       ld_hazard,
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic [BE_W-1:0]            mem_be,
    input  logic                       mem_ack
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] TWO_CNT  = CW'(2);

    logic [DEPTH-1:0]             ent_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
    logic [DEPTH-1:0][DATA_W-1:0] ent_data;
    logic [DEPTH-1:0][BE_W-1:0]   ent_be;
    logic [PW-1:0]                head;
    logic [PW-1:0]                tail;
    logic [PW-1:0]                tail_prev;
    logic [DEPTH-1:0]             youngest_sel;
    logic [DEPTH-1:0]             ld_hit;
    logic [DEPTH-1:0]             merge_hit;
    logic                         do_merge;
    logic                         do_push;
    logic                         do_pop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    store_buf_match #(.DEPTH(DEPTH)) u_ld_match (
        .valid (ent_valid),
        .addrs (ent_addr),
        .key   (ld_chk_addr),
        .hit   (ld_hit)
    );

    store_buf_match #(.DEPTH(DEPTH)) u_merge_match (
        .valid (ent_valid),
        .addrs (ent_addr),
        .key   (wr_addr),
        .hit   (merge_hit)
    );

    // Hazard looks at registered state only; a store pushed this cycle shows up next cycle.
    assign ld_hazard = ld_chk_en && (|ld_hit);

    // Only the youngest entry may absorb a store, and never when it is also the
    // head (count>=2), since the head is already on the memory bus.
    assign tail_prev    = tail - 1'b1;
    assign youngest_sel = {{(DEPTH-1){1'b0}}, 1'b1} << tail_prev;
    assign do_merge     = MERGE && wr_en && (count >= TWO_CNT) && (|(merge_hit & youngest_sel));
    // Full blocks a push even if a pop happens in the same cycle (no bypass).
    assign do_push      = wr_en && (|wr_be) && !full && !do_merge;
    assign do_pop       = mem_req && mem_ack;

    // Head is presented straight from registered storage; zero when nothing is pending.
    assign mem_req   = !empty;
    assign mem_addr  = mem_req ? ent_addr[head] : '0;
    assign mem_wdata = mem_req ? ent_data[head] : '0;
    assign mem_be    = mem_req ? ent_be[head]   : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_valid <= '0;
            ent_addr  <= '0;
            ent_data  <= '0;
            ent_be    <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
        end else begin
            if (do_pop) begin
                ent_valid[head] <= 1'b0;
                head            <= head + 1'b1;
            end
            if (do_merge) begin
                ent_data[tail_prev] <= merge_bytes(ent_data[tail_prev], wr_data, wr_be);
                ent_be[tail_prev]   <= ent_be[tail_prev] | wr_be;
            end
            if (do_push) begin
                ent_valid[tail] <= 1'b1;
                ent_addr[tail]  <= wr_addr;
                ent_data[tail]  <= wr_data;
                ent_be[tail]    <= wr_be;
                tail            <= tail + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_store_write_buffer.sv
// tb/tb_store_write_buffer.sv - directed self-checking bench for store_write_buffer
module tb_store_write_buffer;
    import store_write_buffer_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic [BE_W-1:0]   wr_be = '0;
    logic              full, empty;
    logic [2:0]        count;
    logic              ld_chk_en = 1'b0;
    logic [ADDR_W-1:0] ld_chk_addr = '0;
    logic              ld_hazard;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic              mem_ack = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    store_write_buffer #(.DEPTH(4), .MERGE(1'b1)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .full(full), .empty(empty), .count(count),
        .ld_chk_en(ld_chk_en), .ld_chk_addr(ld_chk_addr), .ld_hazard(ld_hazard),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [29:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        wr_en = 1'b0; wr_be = '0;
    endtask

    task automatic ld_probe(input string tag, input logic en, input logic [29:0] a, input logic exp);
        ld_chk_en = en; ld_chk_addr = a;
        #1;
        check(tag, 32'(ld_hazard), 32'(exp));
        ld_chk_en = 1'b0;
    endtask

    initial begin
        // 1: reset state, then reset mid-drain with 3 entries
        tick(); tick();
        rst = 1'b0;
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_req", 32'(mem_req), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_be", 32'(mem_be), 0);
        ld_probe("rst_hazard", 1'b1, 30'h0, 1'b0);
        push(30'h1, 32'h11111111, BE_WORD);
        check("req_latency", 32'(mem_req), 1);
        push(30'h2, 32'h22222222, BE_WORD);
        push(30'h3, 32'h33333333, BE_WORD);
        check("pre_rst_count", 32'(count), 3);
        mem_ack = 1'b1;
        tick();
        check("mid_drain_addr", 32'(mem_addr), 32'h2);
        mem_ack = 1'b0; rst = 1'b1;
        tick();
        check("mid_rst_req", 32'(mem_req), 0);
        check("mid_rst_count", 32'(count), 0);
        tick();
        rst = 1'b0;
        check("mid_rst_empty", 32'(empty), 1);

        // 2: fill, overflow ignored, merge while full, ordered drain
        for (int i = 0; i < 4; i++) push(30'h10 + 30'(i), 32'hD0000010 + 32'(i), BE_WORD);
        check("fill_full", 32'(full), 1);
        check("fill_count", 32'(count), 4);
        push(30'h14, 32'hDEADBEEF, BE_WORD);
        check("ovf_count", 32'(count), 4);
        ld_probe("ovf_not_stored", 1'b1, 30'h14, 1'b0);
        push(30'h13, 32'hEE000000, 4'b0001);
        check("full_merge_count", 32'(count), 4);
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_req", 32'(mem_req), 1);
            check("drain_addr", 32'(mem_addr), 32'h10 + 32'(i));
            check("drain_data", mem_wdata, (i == 3) ? 32'hEE000013 : 32'hD0000010 + 32'(i));
            check("drain_be", 32'(mem_be), 32'hF);
            tick();
        end
        mem_ack = 1'b0;
        check("drain_empty", 32'(empty), 1);
        check("drain_req_off", 32'(mem_req), 0);

        // 3: merge into youngest non-head entry
        push(30'h20, 32'hAA000000, 4'b0001);
        push(30'h21, 32'hCC000000, 4'b0001);
        push(30'h21, 32'h000000BB, 4'b1000);
        check("merge_count", 32'(count), 2);
        check("merge_head_data", mem_wdata, 32'hAA000000);
        mem_ack = 1'b1;
        tick();
        check("merge_addr", 32'(mem_addr), 32'h21);
        check("merge_be", 32'(mem_be), 32'h9);
        check("merge_data", mem_wdata, 32'hCC0000BB);
        tick();
        mem_ack = 1'b0;
        check("merge_empty", 32'(empty), 1);

        // 4: head entry is locked against merging
        push(30'h30, 32'h30303030, BE_WORD);
        push(30'h30, 32'h00550000, 4'b0010);
        check("lock_count", 32'(count), 2);
        check("lock_head_data", mem_wdata, 32'h30303030);
        check("lock_head_be", 32'(mem_be), 32'hF);
        mem_ack = 1'b1;
        tick();
        check("lock_second_be", 32'(mem_be), 32'h2);
        check("lock_second_data", mem_wdata, 32'h00550000);
        tick();
        mem_ack = 1'b0;

        // 5: load hazard
        push(30'h40, 32'h40404040, BE_WORD);
        ld_probe("hz_hit", 1'b1, 30'h40, 1'b1);
        ld_probe("hz_other", 1'b1, 30'h41, 1'b0);
        ld_probe("hz_disabled", 1'b0, 30'h40, 1'b0);
        wr_en = 1'b1; wr_addr = 30'h41; wr_data = 32'h41414141; wr_be = BE_WORD;
        ld_probe("hz_same_cycle", 1'b1, 30'h41, 1'b0);
        tick();
        wr_en = 1'b0; wr_be = '0;
        ld_probe("hz_next_cycle", 1'b1, 30'h41, 1'b1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        ld_probe("hz_after_ack", 1'b1, 30'h40, 1'b0);
        ld_probe("hz_still_41", 1'b1, 30'h41, 1'b1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        ld_probe("hz_drained", 1'b1, 30'h41, 1'b0);

        // 6: stall holds head stable; push+pop keeps count; ack on empty ignored
        push(30'h50, 32'h50505050, BE_WORD);
        push(30'h51, 32'h51515151, BE_WORD);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_addr", 32'(mem_addr), 32'h50);
            check("stall_data", mem_wdata, 32'h50505050);
            check("stall_be", 32'(mem_be), 32'hF);
        end
        mem_ack = 1'b1;
        push(30'h52, 32'h52525252, 4'b0110);
        check("pushpop_count", 32'(count), 2);
        check("pushpop_addr", 32'(mem_addr), 32'h51);
        tick();
        check("pushpop_next", 32'(mem_be), 32'h6);
        tick();
        check("stall_empty", 32'(empty), 1);
        tick();
        check("ack_empty_count", 32'(count), 0);
        mem_ack = 1'b0;
        push(30'h60, 32'h60606060, 4'b0000);
        check("be_zero_noop", 32'(count), 0);

        // full blocks push even when a pop happens the same cycle
        for (int i = 0; i < 4; i++) push(30'h70 + 30'(i), 32'h70707070, BE_WORD);
        mem_ack = 1'b1;
        push(30'h74, 32'h74747474, BE_WORD);
        mem_ack = 1'b0;
        check("full_nobypass_count", 32'(count), 3);
        ld_probe("full_nobypass_hz", 1'b1, 30'h74, 1'b0);
        check("full_nobypass_head", 32'(mem_addr), 32'h71);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
